// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the rr_mux_arbiter block.
//   state_e          : arbiter FSM state encoding. The two OWN codes are
//                      one-hot, so each grant is a single state register bit.
//   burst_cnt_width(): width of the per-tenure transfer counter,
//                      clog2(MAX_BURST) with a floor of one bit.
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_e;

  // The counter only has to reach MAX_BURST-1. MAX_BURST of 1 or 2 still
  // needs one physical bit.
  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst <= 2) ? 1 : $clog2(max_burst);
  endfunction

endpackage : arb_pkg

// File: rtl/rr_mux_arbiter_mux_reg.sv
// ---------------------------------------------------------------------------
// mux_reg
// WIDTH-bit 2:1 mux feeding a load-enabled output register, plus a valid
// flag that marks the cycle after each load.
//   clk         : system clock, rising edge
//   reset_n     : asynchronous, active-low reset
//   sel_i       : 0 selects in0_i, 1 selects in1_i
//   load_i      : capture the selected input on this edge
//   in0_i/in1_i : data inputs
//   out_o       : registered selected data (holds when not loaded)
//   out_valid_o : high for exactly the cycles following a load
// ---------------------------------------------------------------------------
module mux_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sel_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  output logic [WIDTH-1:0] out_o,
  output logic             out_valid_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q;

  assign out_d = sel_i ? in1_i : in0_i;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_i;
      if (load_i) begin
        out_q <= out_d;
      end
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = valid_q;

endmodule : mux_reg

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter that shares one registered 2:1 mux between two
// requesters. An owner keeps the datapath while it requests. When the other
// side is also waiting, a tenure is capped at MAX_BURST transfers.
//   clk       : system clock, rising edge
//   reset_n   : asynchronous, active-low reset
//   req0/in0  : requester 0 request and data
//   req1/in1  : requester 1 request and data
//   gnt0/gnt1 : registered ownership grants
//   sel       : registered mux select (equals gnt1)
//   out       : registered data captured on each transfer
//   out_valid : out was captured by the previous cycle's transfer
// A transfer is a cycle in which the current owner holds its req high.
// ---------------------------------------------------------------------------
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int             CNT_W    = burst_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  // prio_q names the requester that wins a tie out of IDLE.
  logic             prio_q, prio_d;

  logic   own_req;     // current owner's request
  logic   oth_req;     // the non-owner's request
  logic   oth_id;      // index of the non-owner
  state_e oth_state;   // OWN state of the non-owner
  logic   xfer;

  // These values only matter in the OWN states. In IDLE they are don't-care
  // because xfer is forced low.
  always_comb begin
    own_req   = (state_q == ST_OWN1) ? req1 : req0;
    oth_req   = (state_q == ST_OWN1) ? req0 : req1;
    oth_id    = (state_q == ST_OWN1) ? 1'b0 : 1'b1;
    oth_state = (state_q == ST_OWN1) ? ST_OWN0 : ST_OWN1;
  end

  assign xfer = (state_q != ST_IDLE) && own_req;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output is given a default before the case so no
  // path leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    prio_d      = prio_q;

    unique case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (req0 && req1) begin
          state_d = prio_q ? ST_OWN1 : ST_OWN0;
        end else if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
      end

      ST_OWN0, ST_OWN1: begin
        if (own_req) begin
          if (burst_cnt_q == CNT_LAST) begin
            // The burst cap is reached. Hand over with no bubble if the other
            // side waits. Otherwise wrap and keep the uncontested tenure.
            burst_cnt_d = '0;
            if (oth_req) begin
              state_d = oth_state;
              prio_d  = oth_id;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end else begin
          // The owner dropped its request. The other side always gets
          // priority next, even if that side only requests later from IDLE.
          burst_cnt_d = '0;
          prio_d      = oth_id;
          state_d     = oth_req ? oth_state : ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      prio_q      <= prio_d;
    end
  end

  // The OWN codes are one-hot, so each grant is a state flop and needs no
  // decode logic.
  assign gnt0 = state_q[0];
  assign gnt1 = state_q[1];
  assign sel  = gnt1;

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  mux_reg #(
    .WIDTH(WIDTH)
  ) u_mux_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .sel_i       (sel),
    .load_i      (xfer),
    .in0_i       (in0),
    .in1_i       (in1),
    .out_o       (out),
    .out_valid_o (out_valid)
  );

endmodule : rr_mux_arbiter
